// File: rtl/events_rate_framer.sv
// events_rate_framer
// Reads latched per-channel event counts from the rate counter when a window
// completes, and sends them to the host as a byte frame:
//   HEADER_BYTE, sequence, channel counts (channel 0 first, MSB byte first),
//   checksum (8-bit sum of the sequence and count bytes).
// The frame leaves on a valid/ready byte stream. Every output is a flop.
module events_rate_framer #(
  parameter int          COUNTER_LENGTH = 24,
  parameter int          CHANNEL_NUMBER = 2,
  parameter logic [7:0]  HEADER_BYTE    = 8'hA5
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     enable,
  input  logic                                     events_rate_ready,
  input  logic [CHANNEL_NUMBER*COUNTER_LENGTH-1:0] event_count,
  output logic                                     read,
  output logic                                     clear,
  output logic [7:0]                               tx_data,
  output logic                                     tx_valid,
  input  logic                                     tx_ready,
  output logic                                     overrun,
  input  logic                                     clear_overrun,
  output logic [15:0]                              frame_count
);

  localparam int W     = CHANNEL_NUMBER * COUNTER_LENGTH;
  localparam int NB    = W / 8;
  localparam int IDX_W = $clog2(NB) + 1;

  generate
    if (COUNTER_LENGTH % 8 != 0) begin : g_bad_counter_length
      $error("events_rate_framer: COUNTER_LENGTH must be a multiple of 8");
    end
    if (CHANNEL_NUMBER < 1 || CHANNEL_NUMBER > 16) begin : g_bad_channel_number
      $error("events_rate_framer: CHANNEL_NUMBER must be in 1..16");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_HEADER, S_SEQ, S_DATA, S_CSUM
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       shadow_q, shadow_d;
  logic [7:0]         csum_q, csum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         seq_q, seq_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic               overrun_q, overrun_d;
  logic               en_hist_q, en_hist_d;
  logic               clear_q, clear_d;
  logic               read_q, read_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               hs;

  // A byte leaves when the sink takes the presented one.
  assign hs = tx_valid_q & tx_ready;

  // State register and all datapath/output flops.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
  // pre-edge value of the others regardless of statement order.
  // The shadow register is a plain flop bank, so it is reset along with the
  // rest to keep post-reset frame contents deterministic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      shadow_q      <= '0;
      csum_q        <= '0;
      idx_q         <= '0;
      seq_q         <= '0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
      en_hist_q     <= 1'b0;
      clear_q       <= 1'b0;
      read_q        <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      csum_q        <= csum_d;
      idx_q         <= idx_d;
      seq_q         <= seq_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
      en_hist_q     <= en_hist_d;
      clear_q       <= clear_d;
      read_q        <= read_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
    end
  end

  // Next-state and datapath: frame sequencing, capture, checksum, counters.
  // NOTE: every variable gets a default at the top of a combinational block so
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    csum_d        = csum_q;
    idx_d         = idx_q;
    seq_d         = seq_q;
    frame_count_d = frame_count_q;
    overrun_d     = overrun_q;
    en_hist_d     = enable;
    clear_d       = enable & ~en_hist_q;

    if (clear_overrun) overrun_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Hold off while a window restart is being issued (the edge that
        // raises clear and the cycle clear is high), so read never
        // coincides with clear.
        if (enable && events_rate_ready && !clear_d && !clear_q) state_d = S_READ;
      end
      S_READ: state_d = S_CAPTURE;
      S_CAPTURE: begin
        // Lay the counts out in transmit order: channel 0 in the top bits,
        // so the frame is produced by shifting left one byte at a time.
        for (int ch = 0; ch < CHANNEL_NUMBER; ch++) begin
          shadow_d[(CHANNEL_NUMBER-1-ch)*COUNTER_LENGTH +: COUNTER_LENGTH] =
            event_count[ch*COUNTER_LENGTH +: COUNTER_LENGTH];
        end
        csum_d  = '0;
        state_d = S_HEADER;
      end
      S_HEADER: if (hs) state_d = S_SEQ;
      S_SEQ: begin
        if (hs) begin
          csum_d  = csum_q + tx_data_q;
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (hs) begin
          csum_d   = csum_q + tx_data_q;
          shadow_d = shadow_q << 8;
          idx_d    = idx_q + 1'b1;
          if (idx_q == IDX_W'(NB-1)) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (hs) begin
          seq_d         = seq_q + 8'd1;
          frame_count_d = frame_count_q + 16'd1;
          // A window already pending at frame end was missed; set beats clear.
          if (events_rate_ready) overrun_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state, so outputs come straight from flops.
  always_comb begin
    read_d     = (state_d == S_READ);
    tx_valid_d = 1'b0;
    tx_data_d  = '0;
    unique case (state_d)
      S_HEADER: begin tx_valid_d = 1'b1; tx_data_d = HEADER_BYTE;        end
      S_SEQ:    begin tx_valid_d = 1'b1; tx_data_d = seq_d;              end
      S_DATA:   begin tx_valid_d = 1'b1; tx_data_d = shadow_d[W-1 -: 8]; end
      S_CSUM:   begin tx_valid_d = 1'b1; tx_data_d = csum_d;             end
      default:  ;
    endcase
  end

  assign read        = read_q;
  assign clear       = clear_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign overrun     = overrun_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_events_rate_framer.sv
// Directed bench for events_rate_framer (2 channels x 24 bits).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_events_rate_framer;

  localparam int CL = 24;
  localparam int CN = 2;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           enable = 1'b0;
  logic           events_rate_ready = 1'b0;
  logic [CN*CL-1:0] event_count = {24'h00ABCD, 24'h123456};
  logic           read, clear, tx_valid, overrun;
  logic [7:0]     tx_data;
  logic           tx_ready = 1'b0;
  logic           clear_overrun = 1'b0;
  logic [15:0]    frame_count;

  int checks = 0;
  int errors = 0;

  events_rate_framer #(.COUNTER_LENGTH(CL), .CHANNEL_NUMBER(CN), .HEADER_BYTE(8'hA5)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .events_rate_ready (events_rate_ready),
    .event_count       (event_count),
    .read              (read),
    .clear             (clear),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .overrun           (overrun),
    .clear_overrun     (clear_overrun),
    .frame_count       (frame_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame. mode 0: tx_ready=1; 1: tx_ready toggles; 2: stall 12
  // cycles at the header. The rate counter drops ready when it sees read.
  // mid_change alters event_count once the first byte is valid; raise_rdy
  // re-asserts events_rate_ready and drops enable at the first byte.
  task automatic run_frame(input int mode, input bit mid_change, input bit raise_rdy,
                           output logic [7:0] got [9], output int nreads,
                           output int first_off, output int last_off,
                           output int stall_err, output bit timeout);
    int c, nhs, t_read, t_valid, stall_left;
    bit stalled;
    logic [7:0] held;
    for (int i = 0; i < 9; i++) got[i] = 8'h00;
    c = 0; nhs = 0; nreads = 0; t_read = -100; t_valid = -1; stall_left = 12;
    first_off = -1; last_off = -1; stall_err = 0; stalled = 1'b0; held = 8'h00;
    while (nhs < 9 && c < 150) begin
      step();
      c++;
      if (read === 1'b1) begin
        nreads++;
        t_read = c;
        events_rate_ready = 1'b0;
      end
      if (stalled && (tx_valid !== 1'b1 || tx_data !== held)) stall_err++;
      if (tx_valid === 1'b1 && t_valid < 0) begin
        t_valid = c;
        first_off = c - t_read;
        if (mid_change) event_count = {24'hFFFFFF, 24'hFFFFFF};
        if (raise_rdy) begin
          events_rate_ready = 1'b1;
          enable = 1'b0;
        end
      end
      case (mode)
        1: tx_ready = ((c % 2) == 0);
        2: begin
          if (tx_valid === 1'b1 && stall_left > 0) begin
            tx_ready = 1'b0;
            stall_left--;
          end else tx_ready = 1'b1;
        end
        default: tx_ready = 1'b1;
      endcase
      if (tx_valid === 1'b1 && tx_ready) begin
        got[nhs] = tx_data;
        nhs++;
        last_off = c - t_read;
      end
      stalled = (tx_valid === 1'b1) && !tx_ready;
      held = tx_data;
    end
    timeout = (nhs < 9);
    step();
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++; if (read !== 1'b0) begin errors++; $display("FAIL reset_read got=%b exp=0", read); end
    checks++; if (clear !== 1'b0) begin errors++; $display("FAIL reset_clear got=%b exp=0", clear); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (frame_count !== 16'h0000) begin errors++; $display("FAIL reset_frame_count got=%0d exp=0", frame_count); end
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_enable_clear();
    int reads;
    step(); step();
    checks++; if (clear !== 1'b0) begin errors++; $display("FAIL clear_idle got=%b exp=0", clear); end
    enable = 1'b1;
    step();
    checks++; if (clear !== 1'b1) begin errors++; $display("FAIL clear_pulse got=%b exp=1", clear); end
    step();
    checks++; if (clear !== 1'b0) begin errors++; $display("FAIL clear_one_cycle got=%b exp=0", clear); end
    reads = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (read !== 1'b0) reads++;
    end
    checks++; if (reads !== 0) begin errors++; $display("FAIL read_without_ready got=%0d exp=0", reads); end
  endtask

  task automatic test_frame_basic();
    logic [7:0] got [9];
    logic [7:0] exp_b [9] = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h00, 8'hAB, 8'hCD, 8'h14};
    int nreads, first_off, last_off, stall_err;
    bit timeout;
    events_rate_ready = 1'b1;
    run_frame(0, 1'b0, 1'b0, got, nreads, first_off, last_off, stall_err, timeout);
    checks++; if (timeout) begin errors++; $display("FAIL basic_timeout got=incomplete exp=9 bytes"); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== exp_b[i]) begin errors++; $display("FAIL basic_byte%0d got=%h exp=%h", i, got[i], exp_b[i]); end
    end
    checks++; if (nreads !== 1) begin errors++; $display("FAIL basic_reads got=%0d exp=1", nreads); end
    checks++; if (first_off !== 2) begin errors++; $display("FAIL basic_first_byte_offset got=%0d exp=2", first_off); end
    checks++; if (last_off !== 10) begin errors++; $display("FAIL basic_last_byte_offset got=%0d exp=10", last_off); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_after got=%b exp=0", tx_valid); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL basic_frame_count got=%0d exp=1", frame_count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got [9];
    logic [7:0] exp_b [9] = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h00, 8'hAB, 8'hCD, 8'h15};
    int nreads, first_off, last_off, stall_err;
    bit timeout;
    events_rate_ready = 1'b1;
    run_frame(1, 1'b0, 1'b0, got, nreads, first_off, last_off, stall_err, timeout);
    checks++; if (timeout) begin errors++; $display("FAIL toggle_timeout got=incomplete exp=9 bytes"); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== exp_b[i]) begin errors++; $display("FAIL toggle_byte%0d got=%h exp=%h", i, got[i], exp_b[i]); end
    end
    checks++; if (stall_err !== 0) begin errors++; $display("FAIL toggle_stall_stability got=%0d exp=0", stall_err); end
    checks++; if (nreads !== 1) begin errors++; $display("FAIL toggle_reads got=%0d exp=1", nreads); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL toggle_valid_after got=%b exp=0", tx_valid); end
    checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL toggle_frame_count got=%0d exp=2", frame_count); end
  endtask

  task automatic test_shadow();
    logic [7:0] got [9];
    logic [7:0] exp_b [9] = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h00, 8'hAB, 8'hCD, 8'h16};
    int nreads, first_off, last_off, stall_err;
    bit timeout;
    events_rate_ready = 1'b1;
    run_frame(0, 1'b1, 1'b0, got, nreads, first_off, last_off, stall_err, timeout);
    checks++; if (timeout) begin errors++; $display("FAIL shadow_timeout got=incomplete exp=9 bytes"); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== exp_b[i]) begin errors++; $display("FAIL shadow_byte%0d got=%h exp=%h", i, got[i], exp_b[i]); end
    end
    checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL shadow_frame_count got=%0d exp=3", frame_count); end
    event_count = {24'h00ABCD, 24'h123456};
  endtask

  task automatic test_overrun();
    logic [7:0] got [9];
    int nreads, first_off, last_off, stall_err;
    bit timeout;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_initial got=%b exp=0", overrun); end
    events_rate_ready = 1'b1;
    run_frame(2, 1'b0, 1'b1, got, nreads, first_off, last_off, stall_err, timeout);
    checks++; if (timeout) begin errors++; $display("FAIL overrun_timeout got=incomplete exp=9 bytes"); end
    checks++; if (got[8] !== 8'h17) begin errors++; $display("FAIL overrun_csum got=%h exp=17", got[8]); end
    checks++; if (stall_err !== 0) begin errors++; $display("FAIL overrun_stall_stability got=%0d exp=0", stall_err); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got=%b exp=1", overrun); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL enable_drop_no_restart got=%b exp=0", tx_valid); end
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got=%b exp=0", overrun); end
    events_rate_ready = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) step();
    events_rate_ready = 1'b1;
    clear_overrun = 1'b1;
    run_frame(0, 1'b0, 1'b1, got, nreads, first_off, last_off, stall_err, timeout);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set_wins got=%b exp=1", overrun); end
    clear_overrun = 1'b0;
    checks++; if (frame_count !== 16'd5) begin errors++; $display("FAIL overrun_frame_count got=%0d exp=5", frame_count); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] got [9];
    logic [7:0] exp_b [9] = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h00, 8'hAB, 8'hCD, 8'h14};
    int nreads, first_off, last_off, stall_err, n, c;
    bit timeout;
    events_rate_ready = 1'b0;
    enable = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    events_rate_ready = 1'b1;
    n = 0; c = 0;
    while (n < 4 && c < 60) begin
      step();
      c++;
      if (read === 1'b1) events_rate_ready = 1'b0;
      if (tx_valid === 1'b1) n++;
    end
    step();
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL midreset_pre_valid got=%b exp=1", tx_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL midreset_pre_overrun got=%b exp=1", overrun); end
    #3 reset_n = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL midreset_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (read !== 1'b0) begin errors++; $display("FAIL midreset_read got=%b exp=0", read); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midreset_overrun got=%b exp=0", overrun); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL midreset_frame_count got=%0d exp=0", frame_count); end
    @(negedge clk);
    reset_n = 1'b1;
    events_rate_ready = 1'b1;
    run_frame(0, 1'b0, 1'b0, got, nreads, first_off, last_off, stall_err, timeout);
    checks++; if (timeout) begin errors++; $display("FAIL postreset_timeout got=incomplete exp=9 bytes"); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== exp_b[i]) begin errors++; $display("FAIL postreset_byte%0d got=%h exp=%h", i, got[i], exp_b[i]); end
    end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL postreset_frame_count got=%0d exp=1", frame_count); end
  endtask

  initial begin
    test_reset();
    test_enable_clear();
    test_frame_basic();
    test_back_to_back();
    test_shadow();
    test_overrun();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
